// File: rtl/cassette_port_if.sv
// rtl/cassette_port_if.sv - CPU port strobes and tape byte stream for cassette_port
interface cassette_port_if;
    logic       cs_n;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output cs_n, io_wr, io_rd, din, byte_in, byte_valid,
        input  dout, byte_ready
    );

    modport slave (
        input  cs_n, io_wr, io_rd, din, byte_in, byte_valid,
        output dout, byte_ready
    );
endinterface

// File: rtl/cassette_port.sv
// rtl/cassette_port.sv - Model I cassette port latch and 500-baud FM pulse regenerator
// Defining CASSETTE_AUDIO_MIX_EN adds the registered 2-bit audio speaker mix output.
module cassette_port #(
    parameter int CELL_CYCLES  = 4000,
    parameter int PULSE_CYCLES = 250,
    parameter int DATA_OFFSET  = 2000
) (
    input  logic           clock,
    input  logic           reset_n,
    cassette_port_if.slave bus,
    output logic [1:0]     cas_level,
    output logic           motor,
    output logic           wide_mode,
    output logic           pulse_out,
    output logic           underrun
`ifdef CASSETTE_AUDIO_MIX_EN
    ,
    output logic [1:0]     audio
`endif
);
    localparam int CNT_W = $clog2(CELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CELL_LAST  = CNT_W'(CELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(DATA_OFFSET);
    localparam logic [CNT_W-1:0] DATA_END   = CNT_W'(DATA_OFFSET + PULSE_CYCLES);
    localparam bit CFG_OK = (DATA_OFFSET + PULSE_CYCLES <= CELL_CYCLES) &&
                            (PULSE_CYCLES < DATA_OFFSET);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CELL  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cas_level_q, cas_level_d;
    logic             motor_q, motor_d;
    logic             wide_q, wide_d;
    logic             wr_prev_q, wr_prev_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             underrun_q, underrun_d;
    logic             pulse_q, pulse_d;
    logic             pulse_prev_q, pulse_prev_d;
    logic             latch_q, latch_d;
    logic             byte_ready_q, byte_ready_d;

    logic wr_req;
    logic wr_edge;
    logic motor_off;
    logic accept;
    logic unused_bits;

    assign unused_bits = &{1'b0, bus.din[7:4], bus.io_rd};

    always_comb begin
        wr_req    = bus.io_wr && !bus.cs_n;
        wr_edge   = wr_req && !wr_prev_q;
        motor_off = wr_edge && !bus.din[2];
        accept    = bus.byte_valid && byte_ready_q;

        wr_prev_d    = wr_req;
        cas_level_d  = cas_level_q;
        motor_d      = motor_q;
        wide_d       = wide_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cell_cnt_d   = cell_cnt_q;
        idle_cnt_d   = '0;
        underrun_d   = underrun_q;
        pulse_d      = 1'b0;
        pulse_prev_d = pulse_q;
        latch_d      = latch_q;

        if (wr_edge) begin
            cas_level_d = bus.din[1:0];
            motor_d     = bus.din[2];
            wide_d      = bus.din[3];
            latch_d     = 1'b0;
        end
        // A pulse edge seen in the same cycle as a port write must not be lost.
        if (pulse_q && !pulse_prev_q) begin
            latch_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = bus.byte_in;
                    bit_cnt_d  = 3'd7;
                    cell_cnt_d = '0;
                    state_d    = CELL;
                end else if (motor_q && !bus.byte_valid) begin
                    if (idle_cnt_q == CELL_LAST) begin
                        underrun_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_ONE;
                    end
                end
            end
            CELL: begin
                pulse_d = (cell_cnt_q < PULSE_END) ||
                          (shift_q[7] && (cell_cnt_q >= DATA_START) && (cell_cnt_q < DATA_END));
                if (cell_cnt_q == CELL_LAST) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d    = {shift_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q - 3'd1;
                        cell_cnt_d = '0;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    cell_cnt_d = cell_cnt_q + CNT_ONE;
                end
            end
            FETCH: begin
                if (accept) begin
                    shift_d    = bus.byte_in;
                    bit_cnt_d  = 3'd7;
                    cell_cnt_d = '0;
                    state_d    = CELL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Motor off abandons any byte in flight and silences the pulse train.
        if (motor_off) begin
            state_d    = IDLE;
            pulse_d    = 1'b0;
            cell_cnt_d = '0;
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
            underrun_d = 1'b0;
        end

        byte_ready_d = (state_d == FETCH) || ((state_d == IDLE) && motor_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cas_level_q  <= 2'b00;
            motor_q      <= 1'b0;
            wide_q       <= 1'b0;
            wr_prev_q    <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            cell_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            underrun_q   <= 1'b0;
            pulse_q      <= 1'b0;
            pulse_prev_q <= 1'b0;
            latch_q      <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cas_level_q  <= cas_level_d;
            motor_q      <= motor_d;
            wide_q       <= wide_d;
            wr_prev_q    <= wr_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cell_cnt_q   <= cell_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            underrun_q   <= underrun_d;
            pulse_q      <= pulse_d;
            pulse_prev_q <= pulse_prev_d;
            latch_q      <= latch_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign bus.dout       = {latch_q, 7'b0};
    assign bus.byte_ready = byte_ready_q;
    assign cas_level      = cas_level_q;
    assign motor          = motor_q;
    assign wide_mode      = wide_q;
    assign pulse_out      = pulse_q;
    assign underrun       = underrun_q;

`ifdef CASSETTE_AUDIO_MIX_EN
    logic [1:0] audio_q, audio_d;

    always_comb begin
        audio_d = cas_level_q | {2{pulse_q & motor_q}};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            audio_q <= 2'b00;
        end else begin
            audio_q <= audio_d;
        end
    end

    assign audio = audio_q;
`endif

    always @(posedge clock) begin
        assert (CFG_OK)
            else $error("cassette_port: need DATA_OFFSET+PULSE_CYCLES <= CELL_CYCLES and PULSE_CYCLES < DATA_OFFSET");
    end
endmodule
